// File: rtl/bram_pkg.sv
// -----------------------------------------------------------------------------
// bram_pkg
// Shared definitions for the BRAM stream write port and its read-side sibling.
//   - state_e      : write-port frame FSM states
//   - DEF_W_DATA   : default BRAM data word width
//   - DEF_W_ADDR   : default BRAM address width (frame length is W_ADDR+1 bits)
// -----------------------------------------------------------------------------
package bram_pkg;

    localparam int unsigned DEF_W_DATA = 8;
    localparam int unsigned DEF_W_ADDR = 12;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage : bram_pkg

// File: rtl/bram_stream_wr_port_if.sv
// -----------------------------------------------------------------------------
// bram_stream_wr_port_if
// Groups the input data stream (valid/ready/data) and the single-port BRAM
// write bus driven by the write port.
//   master : stream source / BRAM model side (drives din_*, observes BRAM bus)
//   slave  : the write port (accepts din_*, drives din_ready and BRAM bus)
// Optional macro BRAM_WR_LAST_CHECK_EN adds the din_last stream qualifier.
// -----------------------------------------------------------------------------
interface bram_stream_wr_port_if #(
    parameter int unsigned W_DATA = 8,
    parameter int unsigned W_ADDR = 12
);
    // Input stream
    logic              din_valid;
    logic              din_ready;
    logic [W_DATA-1:0] din_data;
`ifdef BRAM_WR_LAST_CHECK_EN
    logic              din_last;
`endif

    // BRAM write bus
    logic              en;
    logic              we;
    logic [W_ADDR-1:0] addr;
    logic [W_DATA-1:0] data_o;

`ifdef BRAM_WR_LAST_CHECK_EN
    modport master (
        output din_valid, din_data, din_last,
        input  din_ready, en, we, addr, data_o
    );
    modport slave (
        input  din_valid, din_data, din_last,
        output din_ready, en, we, addr, data_o
    );
`else
    modport master (
        output din_valid, din_data,
        input  din_ready, en, we, addr, data_o
    );
    modport slave (
        input  din_valid, din_data,
        output din_ready, en, we, addr, data_o
    );
`endif

endinterface : bram_stream_wr_port_if

// File: rtl/bram_addr_gen.sv
// -----------------------------------------------------------------------------
// bram_addr_gen
// Frame address generator for the BRAM stream write port.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_load     : latch i_base/i_len and clear the word counter
//   i_base     : first address of the frame
//   i_len      : frame length in words (W_ADDR+1 bits, 2^W_ADDR allowed)
//   i_inc      : advance by one word (one accepted beat)
//   o_addr     : current write address, base+cnt modulo 2^W_ADDR
//   o_last     : current word is the final one of the frame (cnt == len-1)
// -----------------------------------------------------------------------------
module bram_addr_gen #(
    parameter int unsigned W_ADDR = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [W_ADDR-1:0] i_base,
    input  logic [W_ADDR:0]   i_len,
    input  logic              i_inc,
    output logic [W_ADDR-1:0] o_addr,
    output logic              o_last
);

    localparam logic [W_ADDR:0] CNT_ONE = (W_ADDR + 1)'(1);

    logic [W_ADDR-1:0] r_base;
    logic [W_ADDR:0]   r_len;
    logic [W_ADDR:0]   r_cnt;   // one bit wider than addr so a full-memory frame fits

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_base <= i_base;
            r_len  <= i_len;
            r_cnt  <= '0;
        end else if (i_inc) begin
            r_cnt  <= r_cnt + CNT_ONE;
        end
    end

    // Dropping the counter MSB gives the modulo-2^W_ADDR wrap for free.
    assign o_addr = r_base + r_cnt[W_ADDR-1:0];

    // With len==0 the compare value is all-ones, which cnt never reaches;
    // the FSM never enters WRITE for such a frame anyway.
    assign o_last = (r_cnt == (r_len - CNT_ONE));

endmodule : bram_addr_gen

// File: rtl/bram_stream_wr_port.sv
// -----------------------------------------------------------------------------
// bram_stream_wr_port
// Writes a frame of i_len words, taken from a valid/ready stream, into a
// single-port BRAM at consecutive addresses from i_base_addr (wrapping modulo
// 2^W_ADDR). Writes are combinational on the accepted beat, so the stream is
// never stalled while a frame is in progress.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_start      : frame start request, honoured in IDLE only
//   i_base_addr  : first write address, latched on accepted start
//   i_len        : words in frame (0 legal), latched on accepted start
//   bus          : stream in (din_*) and BRAM write bus (en/we/addr/data_o)
//   o_busy       : frame in progress (WRITE or DONE)
//   o_done       : one-cycle pulse at frame end
//   o_err        : (BRAM_WR_LAST_CHECK_EN only) sticky din_last/length mismatch
// Optional macro: BRAM_WR_LAST_CHECK_EN enables din_last checking and o_err.
// -----------------------------------------------------------------------------
module bram_stream_wr_port
    import bram_pkg::*;
#(
    parameter int unsigned W_DATA = DEF_W_DATA,
    parameter int unsigned W_ADDR = DEF_W_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [W_ADDR-1:0]     i_base_addr,
    input  logic [W_ADDR:0]       i_len,
    bram_stream_wr_port_if.slave  bus,
    output logic                  o_busy,
`ifdef BRAM_WR_LAST_CHECK_EN
    output logic                  o_err,
`endif
    output logic                  o_done
);

    state_e            r_state;
    state_e            w_next;
    logic              w_load;
    logic              w_beat;
    logic              w_last;
    logic              w_frame_end;
    logic [W_ADDR-1:0] w_addr;

    bram_addr_gen #(
        .W_ADDR (W_ADDR)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_base (i_base_addr),
        .i_len  (i_len),
        .i_inc  (w_beat),
        .o_addr (w_addr),
        .o_last (w_last)
    );

    // ---------------------------------------------------------------------
    // Handshake: ready is a pure state decode, so a beat is just valid in WRITE
    // ---------------------------------------------------------------------
    assign bus.din_ready = (r_state == S_WRITE);
    assign w_beat        = bus.din_valid & bus.din_ready;

`ifdef BRAM_WR_LAST_CHECK_EN
    // An early din_last closes the frame on that beat; the write still happens.
    assign w_frame_end = w_last | bus.din_last;
`else
    assign w_frame_end = w_last;
`endif

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next-state logic
    // ---------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_load = 1'b1;
                    w_next = (i_len == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_beat && w_frame_end) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // BRAM bus: zero-latency write on the accepted beat
    // ---------------------------------------------------------------------
    assign bus.en     = w_beat;
    assign bus.we     = w_beat;
    assign bus.addr   = w_addr;
    assign bus.data_o = bus.din_data;   // only meaningful while we=1

    assign o_busy = (r_state != S_IDLE);
    assign o_done = (r_state == S_DONE);

`ifdef BRAM_WR_LAST_CHECK_EN
    // Sticky mismatch flag: din_last must coincide exactly with the final word.
    // Cleared by reset or by the next accepted start.
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_load) begin
            r_err <= 1'b0;
        end else if (w_beat && (bus.din_last != w_last)) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`endif

endmodule : bram_stream_wr_port
